// File: rtl/eu_iqueue_pkg.sv
// rtl/eu_iqueue_pkg.sv - entry record types and default depth for the execution-unit instruction queue
package eu_iqueue_pkg;

  localparam int IQUEUE_DEPTH = 8;

  typedef struct packed {
    logic [7:0] uid;
    logic [4:0] rd;
    logic [5:0] opcode;
  } type_iqueue_opd;

  typedef union packed {
    logic [31:0] imm;
    struct packed {
      logic [15:0] tag;
      logic [15:0] offset;
    } fwd;
  } union_iqueue_operand;

  typedef struct packed {
    type_iqueue_opd      opd;
    logic                op0m;
    logic                op1m;
    union_iqueue_operand op0;
    union_iqueue_operand op1;
  } type_iqueue_entry;

endpackage

// File: rtl/eu_iqueue_ptr_ctrl.sv
// rtl/eu_iqueue_ptr_ctrl.sv - read/write pointers with wrap bit, occupancy, full/empty and flush
module eu_iqueue_ptr_ctrl #(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  output logic [LOG2_DEPTH-1:0] o_widx,
  output logic [LOG2_DEPTH-1:0] o_ridx,
  output logic [LOG2_DEPTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam logic [LOG2_DEPTH:0] PTR_ONE = {{LOG2_DEPTH{1'b0}}, 1'b1};

  logic [LOG2_DEPTH:0] wptr;
  logic [LOG2_DEPTH:0] rptr;

  // Pointers advance on accepted handshakes; flush clears both and wins over any handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (i_push) wptr <= wptr + PTR_ONE;
      if (i_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  assign o_widx  = wptr[LOG2_DEPTH-1:0];
  assign o_ridx  = rptr[LOG2_DEPTH-1:0];
  assign o_count = wptr - rptr;
  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[LOG2_DEPTH] != rptr[LOG2_DEPTH]) &&
                   (wptr[LOG2_DEPTH-1:0] == rptr[LOG2_DEPTH-1:0]);

endmodule

// File: rtl/eu_iqueue.sv
// rtl/eu_iqueue.sv - per-unit instruction FIFO between dispatch and issue; EU_IQUEUE_BYPASS_EN enables empty-queue bypass
module eu_iqueue
  import eu_iqueue_pkg::*;
#(
  parameter  int DEPTH      = IQUEUE_DEPTH,
  localparam int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  type_iqueue_entry      i_in_entry,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output type_iqueue_entry      o_out_entry,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [LOG2_DEPTH:0]   o_count
);

  type_iqueue_entry storage [DEPTH];
  type_iqueue_entry head;

  logic [LOG2_DEPTH-1:0] widx;
  logic [LOG2_DEPTH-1:0] ridx;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  push_q;
  logic                  pop;

  eu_iqueue_ptr_ctrl #(
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ptr_ctrl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (push_q),
    .i_pop   (pop),
    .o_widx  (widx),
    .o_ridx  (ridx),
    .o_count (o_count),
    .o_full  (full),
    .o_empty (empty)
  );

  // Ready comes from registered occupancy only, so a full queue refuses a push even while popping.
  assign o_in_ready = !full;
  assign push       = i_in_valid & o_in_ready;
  assign pop        = !empty & i_out_ready;
  assign head       = empty ? '0 : storage[ridx];

`ifdef EU_IQUEUE_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // An empty queue forwards the offered entry; if issue takes it, nothing is stored.
  assign bypass      = empty & i_in_valid & !i_flush;
  assign bypass_take = bypass & i_out_ready;
  assign o_out_valid = !empty | bypass;
  assign o_out_entry = bypass ? i_in_entry : head;
  assign push_q      = push & !bypass_take;
`else
  assign o_out_valid = !empty;
  assign o_out_entry = head;
  assign push_q      = push;
`endif

  // Entry storage is not reset; only the pointers define which slots hold live entries.
  always_ff @(posedge i_clk) begin
    if (push_q && !i_flush) storage[widx] <= i_in_entry;
  end

endmodule
